// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared state encodings and payload sizing for pipeline stage buffers
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } buf_state_t;

    localparam int PAYLOAD_W = 32 + 32 + 1;

    // Payload is packed as {pc, inst, bubble}.
    function automatic int payload_w(input int addr_w, input int data_w);
        return addr_w + data_w + 1;
    endfunction

endpackage

// File: rtl/pipeline_entry_reg.sv
// rtl/pipeline_entry_reg.sv - payload register with load enable, sync clear and async reset
module pipeline_entry_reg
    import pipeline_pkg::*;
#(
    parameter int W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipeline_stage_buf.sv
// rtl/pipeline_stage_buf.sv - valid/ready inter-stage buffer for {pc, inst, bubble} with optional skid entry
module pipeline_stage_buf
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter bit SKID_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_inst,
    input  logic                  in_bubble,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  out_bubble,
    output logic [1:0]            level
);

    localparam int PW = payload_w(ADDR_WIDTH, DATA_WIDTH);

    buf_state_t      r_state;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_main_load;
    logic            w_main_bubble;
    logic [PW-1:0]   w_in_payload;
    logic [PW-1:0]   w_main_d;
    logic [PW-1:0]   w_main_q;

    assign w_in_payload = {in_pc, in_inst, in_bubble};
    assign w_in_fire    = in_valid & in_ready & ~flush;
    assign w_out_fire   = out_valid & out_ready;

    assign out_valid = (r_state != ST_EMPTY);
    assign level     = r_state;
    assign {out_pc, out_inst, w_main_bubble} = w_main_q;
    assign out_bubble = ~out_valid | w_main_bubble;

    pipeline_entry_reg #(.W(PW)) u_main (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (flush),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic          r_in_ready;
            logic          w_skid_load;
            logic [PW-1:0] w_skid_q;

            // In SKID the head refills from the skid entry; otherwise main takes the input.
            assign w_main_load = (r_state == ST_SKID) ? w_out_fire
                                : (w_in_fire & ((r_state == ST_EMPTY) | w_out_fire));
            assign w_main_d    = (r_state == ST_SKID) ? w_skid_q : w_in_payload;
            assign w_skid_load = (r_state == ST_FULL) & w_in_fire & ~w_out_fire;
            assign in_ready    = r_in_ready;

            pipeline_entry_reg #(.W(PW)) u_skid (
                .clk    (clk),
                .rst    (rst),
                .i_clr  (flush),
                .i_load (w_skid_load),
                .i_d    (w_in_payload),
                .o_q    (w_skid_q)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end else if (flush) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_fire) begin
                                r_state <= ST_FULL;
                            end
                        end
                        ST_FULL: begin
                            if (w_in_fire && !w_out_fire) begin
                                r_state    <= ST_SKID;
                                r_in_ready <= 1'b0;
                            end else if (!w_in_fire && w_out_fire) begin
                                r_state <= ST_EMPTY;
                            end
                        end
                        ST_SKID: begin
                            if (w_out_fire) begin
                                r_state    <= ST_FULL;
                                r_in_ready <= 1'b1;
                            end
                        end
                        default: begin
                            r_state    <= ST_EMPTY;
                            r_in_ready <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            // Single entry: a stalled head may be replaced on the same edge it drains.
            assign in_ready    = ~out_valid | out_ready;
            assign w_main_load = w_in_fire;
            assign w_main_d    = w_in_payload;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= ST_EMPTY;
                end else if (flush) begin
                    r_state <= ST_EMPTY;
                end else if (w_in_fire) begin
                    r_state <= ST_FULL;
                end else if (w_out_fire) begin
                    r_state <= ST_EMPTY;
                end
            end
        end
    endgenerate

endmodule

// File: doc/pipeline_stage_buf.md
Name: pipeline_stage_buf

Overview:
- Parametrised successor to the fixed fetch-to-decode pipeline register. It is a generic inter-stage buffer carrying pc, instruction and bubble flag.
- Adds a valid/ready handshake and an optional skid entry, so backpressure (stall) does not need a combinational path from the downstream stage to the upstream stage.
- Flush invalidates all held entries.
- Instantiated between every pair of pipeline stages (fetch/decode, decode/execute, ...).

Parameters:
- DATA_WIDTH, 32, width of inst payload
- ADDR_WIDTH, 32, width of pc payload
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard all held entries this cycle
- in_valid  in  1  upstream has an entry
- in_ready  out  1  buffer accepts entry this cycle
- in_pc  in  ADDR_WIDTH  upstream pc
- in_inst  in  DATA_WIDTH  upstream instruction
- in_bubble  in  1  upstream entry is a bubble
- out_valid  out  1  buffer presents an entry
- out_ready  in  1  downstream accepts (deasserted = stall)
- out_pc  out  ADDR_WIDTH  head pc
- out_inst  out  DATA_WIDTH  head instruction
- out_bubble  out  1  head is a bubble, or no entry is held
- level  out  2  entries held (0..2; max 1 when SKID_EN=0)

Behaviour:
- Handshake rules:
  - in_fire = in_valid & in_ready & !flush.
  - out_fire = out_valid & out_ready.
- Storage:
  - main entry {pc, inst, bubble} drives the out_* payload.
  - skid entry is present only when SKID_EN=1.
- State (SKID_EN=1): EMPTY, FULL, SKID, encoded in 2 bits; level = 0/1/2 respectively.
  - EMPTY: in_fire -> FULL, main<=in.
  - FULL:
    - in_fire & out_fire -> FULL, main<=in.
    - out_fire only -> EMPTY.
    - in_fire only -> SKID, skid<=in.
    - neither -> hold.
  - SKID: out_fire -> FULL, main<=skid (in_ready is 0, so no input is taken); otherwise hold.
- in_ready (SKID_EN=1) is registered: in_ready = (state != SKID). No combinational path from out_ready to in_ready.
- SKID_EN=0: single entry.
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire -> main<=in, valid=1.
  - out_fire without in_fire -> valid=0.
- Outputs:
  - out_valid = (state != EMPTY).
  - out_bubble = !out_valid | main.bubble.
  - Payload outputs are registered from main; zero whenever the buffer is EMPTY after reset or flush.
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput is 1 entry/cycle while out_ready=1.
- Ordering: strict FIFO. The skid entry is always younger than main.
- flush:
  - Highest priority after rst. Next state EMPTY, main and skid payloads cleared to 0, level=0.
  - An input offered in the flush cycle is dropped.
  - An out_fire in the flush cycle still counts downstream (the head was presented); the buffer does not re-present it.
  - in_ready in the cycle after flush = 1.
- rst: asynchronous; beats flush and all other inputs. All outputs reset as follows:
  - out_valid=0, out_pc=0, out_inst=0, out_bubble=1, level=0.
  - in_ready=1 (registered form) or 1 (combinational form, since out_valid=0).
  - Mid-operation reset discards held entries immediately.
- Payload is not required to stay stable while !out_valid, beyond the zero-after-clear rule above.
- Illegal: none. in_valid while !in_ready simply holds upstream; the buffer never overflows.

Decomposition:
- Shared package (pipeline_pkg): state encodings ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2; payload bundle width constant PAYLOAD_W = ADDR_WIDTH+DATA_WIDTH+1.
- Sub-module pipeline_entry_reg: width-parametrised register with load enable, synchronous clear and async reset. Instantiated as main and, under SKID_EN, skid.

Test Plan:
1. Reset: hold rst=1 mid-stream with two entries held -> out_valid=0, out_bubble=1, level=0, in_ready=1 immediately, without a clock edge.
2. Streaming: out_ready=1, in_valid=1, pc=0x00,0x04,0x08 on consecutive cycles -> out_pc 0x00,0x04,0x08 one cycle later, level stays 1, in_ready stays 1.
3. Stall/skid (SKID_EN=1): FULL holding pc=0x10; out_ready=0 while pc=0x14 offered -> level=2, in_ready=0 next cycle. Release out_ready -> out 0x10 then 0x14; 0x18 is not accepted until in_ready returns to 1.
4. Flush in SKID state with in_valid=1, pc=0x20 -> next cycle level=0, out_valid=0, out_pc=0, out_inst=0, out_bubble=1, in_ready=1; 0x20 never appears at the output.
5. Bubble: in_bubble=1, inst=0 accepted -> out_valid=1, out_bubble=1. Next entry with in_bubble=0 -> out_bubble=0.
6. SKID_EN=0: FULL, out_ready=0 -> in_ready=0 in the same cycle. Set out_ready=1 with in_valid=1 -> in_ready=1 and the head is replaced on the same edge, level stays 1.
